// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch history table predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - bp_entry_t: one table entry {valid, tag, target, cnt}
//   - bp_idx / bp_tag: PC field extraction for a given index/tag width
// The entry struct is sized for the widest supported configuration
// (ADDR_W <= 64, TAG_W <= 32). A narrower instance zero-extends into it,
// so the upper field bits of every entry stay constant zero.
// ---------------------------------------------------------------------------
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;   // strongly not-taken
   localparam logic [1:0] WNT = 2'b01;   // weakly not-taken
   localparam logic [1:0] WT  = 2'b10;   // weakly taken
   localparam logic [1:0] ST  = 2'b11;   // strongly taken

   localparam int BP_MAX_ADDR_W = 64;
   localparam int BP_MAX_TAG_W  = 32;

   typedef struct packed {
      logic                     valid;
      logic [BP_MAX_TAG_W-1:0]  tag;
      logic [BP_MAX_ADDR_W-1:0] target;
      logic [1:0]               cnt;
   } bp_entry_t;

   // Table index: pc[idx_w+1:2]; the byte offset bits [1:0] are ignored.
   function automatic logic [BP_MAX_ADDR_W-1:0] bp_idx(
      input logic [BP_MAX_ADDR_W-1:0] pc,
      input int                       idx_w
   );
      bp_idx = (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   // Partial tag: the tag_w bits directly above the index field.
   function automatic logic [BP_MAX_ADDR_W-1:0] bp_tag(
      input logic [BP_MAX_ADDR_W-1:0] pc,
      input int                       idx_w,
      input int                       tag_w
   );
      bp_tag = (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
   endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// ---------------------------------------------------------------------------
// bp_sat_cnt
// Next-state function of a 2-bit saturating branch counter.
// Ports:
//   cnt      in  2  current counter value
//   taken    in  1  resolved outcome (count up when set, down otherwise)
//   force_st in  1  unconditional jump: force strongly taken
//   cnt_next out 2  next counter value (saturates at SNT and ST)
// ---------------------------------------------------------------------------
module bp_sat_cnt
   import bp_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   input  logic       force_st,
   output logic [1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (force_st) begin
         cnt_next = ST;
      end else if (taken) begin
         cnt_next = (cnt == ST) ? ST : cnt + 2'd1;
      end else begin
         cnt_next = (cnt == SNT) ? SNT : cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. IF looks up pc_if combinationally every cycle; Mem-stage resolution
// trains the table one cycle later and raises mispredict/redirect_pc.
// Ports:
//   clk, rst (sync, active low), clear (sync table invalidate)
//   pc_if                                   IF-stage lookup PC
//   pred_hit / pred_taken / pred_target     lookup result
//   upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
//   upd_pred_taken, upd_pred_target         Mem-stage resolution
//   mispredict / redirect_pc                flush request and correct PC
//   branch_cnt / mispredict_cnt             saturating statistics
// ---------------------------------------------------------------------------
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int         ADDR_W   = 32,
   parameter int         ENTRIES  = 64,
   parameter int         TAG_W    = 8,
   parameter logic [1:0] CNT_INIT = WNT,
   parameter int         STAT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [ADDR_W-1:0] pc_if,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic              upd_is_jump,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispredict_cnt
);

   localparam int                IDX_W   = $clog2(ENTRIES);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   bp_entry_t tbl_q [ENTRIES];

   // ---------------- lookup (reads pre-update state, no bypass) -----------
   logic [BP_MAX_ADDR_W-1:0] pc_if_ext;
   logic [IDX_W-1:0]         if_idx;
   logic [TAG_W-1:0]         if_tag;
   bp_entry_t                if_entry;

   assign pc_if_ext = BP_MAX_ADDR_W'(pc_if);
   assign if_idx    = IDX_W'(bp_idx(pc_if_ext, IDX_W));
   assign if_tag    = TAG_W'(bp_tag(pc_if_ext, IDX_W, TAG_W));
   assign if_entry  = tbl_q[if_idx];

   assign pred_hit    = if_entry.valid && (if_entry.tag == BP_MAX_TAG_W'(if_tag));
   assign pred_taken  = pred_hit && if_entry.cnt[1];
   assign pred_target = pred_taken ? ADDR_W'(if_entry.target) : pc_if + PC_STEP;

   // ---------------- resolution ------------------------------------------
   logic [ADDR_W-1:0] actual_next;

   assign actual_next = upd_taken ? upd_target : upd_pc + PC_STEP;
   // The carried target already encodes the direction prediction, so the
   // target compare alone decides a flush.
   assign mispredict  = upd_valid && (upd_pred_target != actual_next);
   assign redirect_pc = actual_next;

   logic unused_upd_pred_taken;
   assign unused_upd_pred_taken = upd_pred_taken;

   // ---------------- update path -----------------------------------------
   logic [BP_MAX_ADDR_W-1:0] upd_pc_ext;
   logic [IDX_W-1:0]         upd_idx;
   logic [TAG_W-1:0]         upd_tag;
   bp_entry_t                upd_rd;
   logic                     upd_hit;
   logic [1:0]               upd_cnt_next;
   bp_entry_t                upd_entry;
   logic                     tbl_we;
   logic [ENTRIES-1:0]       we_vec;

   assign upd_pc_ext = BP_MAX_ADDR_W'(upd_pc);
   assign upd_idx    = IDX_W'(bp_idx(upd_pc_ext, IDX_W));
   assign upd_tag    = TAG_W'(bp_tag(upd_pc_ext, IDX_W, TAG_W));
   assign upd_rd     = tbl_q[upd_idx];
   assign upd_hit    = upd_rd.valid && (upd_rd.tag == BP_MAX_TAG_W'(upd_tag));

   bp_sat_cnt u_sat_cnt (
      .cnt      (upd_rd.cnt),
      .taken    (upd_taken),
      .force_st (upd_is_jump),
      .cnt_next (upd_cnt_next)
   );

   always_comb begin
      upd_entry = upd_rd;
      tbl_we    = 1'b0;
      if (upd_valid) begin
         if (upd_hit) begin
            tbl_we        = 1'b1;
            upd_entry.cnt = upd_cnt_next;
            if (upd_taken || upd_is_jump) begin
               upd_entry.target = BP_MAX_ADDR_W'(upd_target);
            end
         end else if (upd_taken) begin
            // Miss on a taken instruction: (re)allocate, evicting any alias.
            tbl_we           = 1'b1;
            upd_entry.valid  = 1'b1;
            upd_entry.tag    = BP_MAX_TAG_W'(upd_tag);
            upd_entry.target = BP_MAX_ADDR_W'(upd_target);
            upd_entry.cnt    = upd_is_jump ? ST : WT;
         end
      end
   end

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_we
      assign we_vec[gi] = tbl_we && (upd_idx == IDX_W'(gi));
   end

   // Reset beats clear, clear beats a same-cycle update.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (!rst) begin
            tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
         end else if (clear) begin
            tbl_q[i].valid <= 1'b0;
            tbl_q[i].cnt   <= CNT_INIT;
         end else if (we_vec[i]) begin
            tbl_q[i] <= upd_entry;
         end
      end
   end

   // ---------------- statistics (saturating, kept across clear) ----------
   logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (upd_valid && !(&branch_cnt_q)) begin
         branch_cnt_d = branch_cnt_q + STAT_W'(1);
      end
      if (mispredict && !(&mispredict_cnt_q)) begin
         mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
// Directed scenarios followed by randomized traffic, every output compared
// against a table-of-integers reference model of the predictor rules.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

   localparam int NE   = 64;
   localparam int SMAX = 15;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic [31:0] pc_if;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [3:0]  branch_cnt, mispredict_cnt;

   always #5 clk = ~clk;

   branch_predictor_bht #(
      .ADDR_W(32), .ENTRIES(NE), .TAG_W(8), .CNT_INIT(2'b01), .STAT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .pc_if(pc_if),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_valid [NE];
   logic [7:0]  m_tag   [NE];
   logic [31:0] m_tgt   [NE];
   int          m_cnt   [NE];
   int          m_br, m_mis;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % NE);
   endfunction

   function automatic logic [7:0] mtag(input logic [31:0] pc);
      return pc[15:8];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
      end
      m_br = 0; m_mis = 0;
   endtask

   task automatic model_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                               output logic [31:0] tgt);
      int i;
      i   = midx(pc);
      hit = m_valid[i] && (m_tag[i] == mtag(pc));
      tk  = hit && (m_cnt[i] >= 2);
      tgt = tk ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic model_commit(input bit mis);
      int  i;
      bit  hit;
      if (!rst) begin
         model_reset();
      end else begin
         if (upd_valid) begin
            if (m_br < SMAX) m_br++;
            if (mis && m_mis < SMAX) m_mis++;
         end
         if (clear) begin
            for (int k = 0; k < NE; k++) begin
               m_valid[k] = 0; m_cnt[k] = 1;
            end
         end else if (upd_valid) begin
            i   = midx(upd_pc);
            hit = m_valid[i] && (m_tag[i] == mtag(upd_pc));
            if (hit) begin
               if (upd_is_jump) begin
                  m_cnt[i] = 3; m_tgt[i] = upd_target;
               end else if (upd_taken) begin
                  m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                  m_tgt[i] = upd_target;
               end else begin
                  m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
               end
            end else if (upd_taken) begin
               m_valid[i] = 1; m_tag[i] = mtag(upd_pc); m_tgt[i] = upd_target;
               m_cnt[i]   = upd_is_jump ? 3 : 2;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      upd_valid = 0; upd_is_jump = 0; upd_pc = '0; upd_taken = 0;
      upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0; clear = 0;
   endtask

   task automatic set_upd(input bit jump, input logic [31:0] pc, input bit taken,
                          input logic [31:0] tgt, input logic [31:0] ptgt);
      upd_valid = 1; upd_is_jump = jump; upd_pc = pc; upd_taken = taken;
      upd_target = tgt; upd_pred_target = ptgt; upd_pred_taken = (ptgt != pc + 32'd4);
   endtask

   // One clock: check lookup/resolution outputs mid-cycle, then the stats.
   task automatic run_cycle(input string tag);
      bit          h, t, mis;
      logic [31:0] tg, an;
      #2;
      model_lookup(pc_if, h, t, tg);
      check_val({tag, ".hit"}, pred_hit, h);
      check_val({tag, ".taken"}, pred_taken, t);
      check_val({tag, ".ptgt"}, pred_target, tg);
      an  = upd_taken ? upd_target : upd_pc + 32'd4;
      mis = upd_valid && (upd_pred_target != an);
      check_val({tag, ".mispredict"}, mispredict, mis);
      if (upd_valid) begin
         check_val({tag, ".redirect"}, redirect_pc, an);
         $display("upd %s pc=%08h taken=%0b jump=%0b tgt=%08h pred=%08h mispredict=%0b",
                  tag, upd_pc, upd_taken, upd_is_jump, upd_target, upd_pred_target, mispredict);
      end
      @(posedge clk);
      model_commit(mis);
      #1;
      check_val({tag, ".brcnt"}, branch_cnt, m_br);
      check_val({tag, ".miscnt"}, mispredict_cnt, m_mis);
   endtask

   // Idle cycle with a lookup compared against hand-derived values.
   task automatic expect_lookup(input string tag, input logic [31:0] pc, input bit hit,
                                input bit tk, input logic [31:0] tgt);
      idle();
      pc_if = pc;
      #2;
      check_val({tag, ".hit"}, pred_hit, hit);
      check_val({tag, ".taken"}, pred_taken, tk);
      check_val({tag, ".ptgt"}, pred_target, tgt);
      @(posedge clk);
      model_commit(0);
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
      return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int          br_before;
      bit          h, t;
      logic [31:0] tg, p;

      rst = 0; idle(); pc_if = 32'h100;
      @(posedge clk); model_reset(); #1;

      // reset state
      expect_lookup("reset", 32'h100, 0, 0, 32'h104);
      check_val("reset.brcnt", branch_cnt, 0);
      check_val("reset.miscnt", mispredict_cnt, 0);
      rst = 1;

      // first taken branch allocates with WT
      pc_if = 32'h100; set_upd(0, 32'h100, 1, 32'h40, 32'h104);
      #1; check_val("alloc.mispredict", mispredict, 1);
      check_val("alloc.redirect", redirect_pc, 32'h40);
      run_cycle("alloc");
      expect_lookup("alloc.next", 32'h100, 1, 1, 32'h40);
      check_val("alloc.brcnt1", branch_cnt, 1);
      check_val("alloc.miscnt1", mispredict_cnt, 1);

      // three not-taken updates walk the counter down to SNT
      set_upd(0, 32'h100, 0, 32'h40, 32'h40);  run_cycle("nt1");
      set_upd(0, 32'h100, 0, 32'h40, 32'h104); run_cycle("nt2");
      set_upd(0, 32'h100, 0, 32'h40, 32'h104); run_cycle("nt3");
      expect_lookup("nt.after", 32'h100, 1, 0, 32'h104);
      check_val("nt.brcnt", branch_cnt, 4);
      check_val("nt.miscnt", mispredict_cnt, 2);

      // aliasing at idx 0
      expect_lookup("alias.miss", 32'h200, 0, 0, 32'h204);
      set_upd(1, 32'h200, 1, 32'h800, 32'h204); run_cycle("alias.jump");
      expect_lookup("alias.new", 32'h200, 1, 1, 32'h800);
      expect_lookup("alias.old", 32'h100, 0, 0, 32'h104);

      // same-cycle update and lookup: lookup shows pre-update counter
      pc_if = 32'h200; set_upd(0, 32'h200, 0, 32'h800, 32'h800); run_cycle("same1");
      pc_if = 32'h200; set_upd(0, 32'h200, 0, 32'h800, 32'h800);
      #1; check_val("same2.old_taken", pred_taken, 1);
      run_cycle("same2");
      expect_lookup("same.new", 32'h200, 1, 0, 32'h204);

      // clear wins over a same-cycle update; statistics still count it
      br_before = m_br;
      pc_if = 32'h200; set_upd(0, 32'h200, 1, 32'h900, 32'h204); clear = 1;
      run_cycle("clear");
      check_val("clear.brcnt", branch_cnt, br_before + 1);
      expect_lookup("clear.empty", 32'h200, 0, 0, 32'h204);

      // statistic saturation
      for (int i = 0; i < 20; i++) begin
         pc_if = 32'h300; set_upd(0, 32'h300 + 32'(i * 4), 1, 32'h40, 32'h0);
         run_cycle("sat");
      end
      check_val("sat.brcnt", branch_cnt, 15);
      check_val("sat.miscnt", mispredict_cnt, 15);

      // reset mid-stream
      rst = 0; pc_if = 32'h300; set_upd(0, 32'h100, 1, 32'h40, 32'h104);
      run_cycle("midrst");
      rst = 1;
      check_val("midrst.brcnt", branch_cnt, 0);
      check_val("midrst.miscnt", mispredict_cnt, 0);
      expect_lookup("midrst.empty", 32'h300, 0, 0, 32'h304);

      // wrap at the top of address space
      expect_lookup("wrap.lookup", 32'hFFFF_FFFC, 0, 0, 32'h0);
      pc_if = 32'hFFFF_FFFC; set_upd(0, 32'hFFFF_FFFC, 0, 32'h80, 32'h4);
      #1; check_val("wrap.redirect", redirect_pc, 32'h0);
      run_cycle("wrap");

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         idle();
         rst   = ($urandom_range(0, 59) != 0);
         clear = ($urandom_range(0, 39) == 0);
         pc_if = rand_pc();
         if ($urandom_range(0, 3) != 0) begin
            p = rand_pc();
            model_lookup(p, h, t, tg);
            if ($urandom_range(0, 4) == 0) tg = rand_pc();
            if ($urandom_range(0, 5) == 0)
               set_upd(1, p, 1, $urandom() & 32'hFFFF_FFFC, tg);
            else
               set_upd(0, p, 1'($urandom_range(0, 1)), $urandom() & 32'h0000_0FFC, tg);
         end
         run_cycle("rand");
      end
      rst = 1; idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
